// File: rtl/sram_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bus_ctrl
//   Synchronous front-end for an asynchronous static RAM (6116/62256 style).
//   Takes single read/write requests on a valid/ready handshake and turns each
//   one into a timed strobe sequence on the RAM pins. Each sequence has address
//   and data setup and hold, and a bus turnaround gap at the end. Read data is
//   returned with a one-cycle response strobe.
//
// Ports
//   clk        : single clock, every state change on the rising edge
//   reset      : synchronous, active-high reset
//   req_valid  : request present
//   req_ready  : controller can accept (high only in IDLE)
//   req_write  : 1 = write, 0 = read (sampled on accept)
//   req_addr   : request address (sampled on accept)
//   req_wdata  : write data (sampled on accept)
//   rsp_valid  : one-cycle pulse, rsp_rdata is valid
//   rsp_rdata  : read data, held until the next read completes
//   _OE        : RAM output enable, active low
//   _WE        : RAM write enable, active low
//   A          : RAM address, registered
//   D          : RAM data bus, driven only during write states, else high-Z
// -----------------------------------------------------------------------------
module sram_bus_ctrl #(
   parameter int DWIDTH   = 8,
   parameter int AWIDTH   = 16,
   parameter int RD_WAIT  = 2,   // cycles _OE is low before D is sampled (>=1)
   parameter int WR_PULSE = 2,   // cycles _WE is low (>=1)
   parameter int TURN     = 1    // idle cycles after every op (>=0)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              _OE,
   output logic              _WE,
   output logic [AWIDTH-1:0] A,
   inout  wire  [DWIDTH-1:0] D
);

   // One down-counter times RD, WR_PULSE and TURN, so it is sized for the longest.
   localparam int CMAX = (RD_WAIT > WR_PULSE) ?
                         ((RD_WAIT  > TURN) ? RD_WAIT  : TURN) :
                         ((WR_PULSE > TURN) ? WR_PULSE : TURN);
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_TURN
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                d_en, d_en_nxt;
   logic [DWIDTH-1:0]   d_out, d_out_nxt;
   logic                oe_nxt, we_nxt, ready_nxt, rsp_valid_nxt;
   logic [AWIDTH-1:0]   a_nxt;
   logic [DWIDTH-1:0]   rsp_rdata_nxt;

   // The data pins are released whenever the controller is not writing.
   assign D = d_en ? d_out : {DWIDTH{1'bz}};

   // Next-state and next-output logic. Every pin is computed here and then
   // registered, so the RAM strobes come straight from flops.
   always_comb begin
      // NOTE: every variable gets a default before the case statement; a path
      // that leaves one unassigned would infer a latch.
      state_nxt     = state;
      cnt_nxt       = cnt;
      a_nxt         = A;
      d_out_nxt     = d_out;
      d_en_nxt      = 1'b0;
      oe_nxt        = 1'b1;
      we_nxt        = 1'b1;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = rsp_rdata;

      unique case (state)
         S_IDLE: begin
            if (req_valid) begin
               a_nxt = req_addr;
               if (req_write) begin
                  state_nxt = S_WR_SETUP;
                  d_en_nxt  = 1'b1;
                  d_out_nxt = req_wdata;
               end else begin
                  state_nxt = S_RD;
                  oe_nxt    = 1'b0;
                  cnt_nxt   = CW'(RD_WAIT - 1);
               end
            end
         end

         S_RD: begin
            if (cnt == '0) begin
               // D is sampled on the same edge that raises _OE.
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = D;
               state_nxt     = (TURN > 0) ? S_TURN : S_IDLE;
               cnt_nxt       = CW'((TURN > 0) ? TURN - 1 : 0);
            end else begin
               cnt_nxt = cnt - 1'b1;
               oe_nxt  = 1'b0;
            end
         end

         S_WR_SETUP: begin
            state_nxt = S_WR_PULSE;
            we_nxt    = 1'b0;
            d_en_nxt  = 1'b1;
            cnt_nxt   = CW'(WR_PULSE - 1);
         end

         S_WR_PULSE: begin
            d_en_nxt = 1'b1;
            if (cnt == '0) begin
               state_nxt = S_WR_HOLD;
            end else begin
               cnt_nxt = cnt - 1'b1;
               we_nxt  = 1'b0;
            end
         end

         S_WR_HOLD: begin
            // _WE is already high here; data is released on the next edge.
            state_nxt = (TURN > 0) ? S_TURN : S_IDLE;
            cnt_nxt   = CW'((TURN > 0) ? TURN - 1 : 0);
         end

         S_TURN: begin
            if (cnt == '0) state_nxt = S_IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end

         default: state_nxt = S_IDLE;
      endcase

      ready_nxt = (state_nxt == S_IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples the pre-edge values regardless of statement order.
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         A         <= '0;
         d_out     <= '0;
         d_en      <= 1'b0;
         _OE       <= 1'b1;
         _WE       <= 1'b1;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         A         <= a_nxt;
         d_out     <= d_out_nxt;
         d_en      <= d_en_nxt;
         _OE       <= oe_nxt;
         _WE       <= we_nxt;
         req_ready <= ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
      end
   end

   // Bus-safety invariants.
   a_no_strobe_overlap: assert property (@(posedge clk) disable iff (reset)
      !(!_OE && !_WE));
   a_no_contention: assert property (@(posedge clk) disable iff (reset)
      !(!_OE && d_en));
   a_we_with_data: assert property (@(posedge clk) disable iff (reset)
      !_WE |-> (d_en && $stable(A)));

endmodule
